// File: rtl/pulse_gen.sv
// Pulse-event transmitter: queues evt_in requests and launches WIDTH-cycle pulses at least GAP cycles apart.
// Optional PULSE_GEN_TOGGLE_EN adds toggle_out, which flips on every launch.
module pulse_gen #(
  parameter int unsigned GAP   = 8,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 15,
  localparam int unsigned PW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          evt_in,
  input  logic          clr_ovf,
  output logic          pulse_out,
  output logic [PW-1:0] pending,
  output logic          busy,
`ifdef PULSE_GEN_TOGGLE_EN
  output logic          toggle_out,
`endif
  output logic          overflow
);

  localparam int unsigned PHW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PHW-1:0]  ph_q, ph_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            pulse_q, pulse_d;
  logic            launch_ok, launch, acc, drop;
`ifdef PULSE_GEN_TOGGLE_EN
  logic            tog_q, tog_d;
`endif

  // Next-state, queue and flag logic
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    launch_ok = (state_q == IDLE) || ((state_q == LOW) && (ph_q == PHW'(GAP - 1)));
    launch    = launch_ok && ((pend_q != '0) || evt_in);
    acc       = evt_in && ((pend_q < PW'(DEPTH)) || launch);
    drop      = evt_in && !acc;

    unique case (state_q)
      IDLE: ph_d = '0;
      HIGH: begin
        ph_d = ph_q + PHW'(1);
        if (ph_q == PHW'(WIDTH - 1)) state_d = LOW;
      end
      LOW: begin
        ph_d = ph_q + PHW'(1);
        if (ph_q == PHW'(GAP - 1)) begin
          state_d = IDLE;
          ph_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase

    if (launch) begin
      state_d = HIGH;
      ph_d    = '0;
    end

    // Accept and launch in the same cycle cancel out; a launch from empty consumes evt_in directly
    pend_d = pend_q;
    if (acc && !launch)      pend_d = pend_q + PW'(1);
    else if (!acc && launch) pend_d = pend_q - PW'(1);

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    pulse_d = (state_d == HIGH);
`ifdef PULSE_GEN_TOGGLE_EN
    tog_d = tog_q ^ launch;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
`ifdef PULSE_GEN_TOGGLE_EN
      tog_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
`ifdef PULSE_GEN_TOGGLE_EN
      tog_q   <= tog_d;
`endif
    end
  end

  assign pulse_out = pulse_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || (pend_q != '0);
`ifdef PULSE_GEN_TOGGLE_EN
  assign toggle_out = tog_q;
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: directed tables, corner sequences and random traffic vs a timing model.
module tb_pulse_gen;

  localparam int unsigned GAP   = 8;
  localparam int unsigned WIDTH = 1;
  localparam int unsigned DEPTH = 15;
  localparam int unsigned PW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, evt, clr;
  logic          pulse, busy, ovf;
  logic [PW-1:0] pend;
  logic          evt2, clr2, pulse2, busy2, ovf2;
  logic [3:0]    pend2;
`ifdef PULSE_GEN_TOGGLE_EN
  logic          tog, tog2;
`endif

  pulse_gen u_dut (
    .clk(clk), .rst_n(rst_n), .evt_in(evt), .clr_ovf(clr),
    .pulse_out(pulse), .pending(pend), .busy(busy),
`ifdef PULSE_GEN_TOGGLE_EN
    .toggle_out(tog),
`endif
    .overflow(ovf)
  );

  pulse_gen #(.GAP(5), .WIDTH(3)) u_shape (
    .clk(clk), .rst_n(rst_n), .evt_in(evt2), .clr_ovf(clr2),
    .pulse_out(pulse2), .pending(pend2), .busy(busy2),
`ifdef PULSE_GEN_TOGGLE_EN
    .toggle_out(tog2),
`endif
    .overflow(ovf2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_l, m_pend, m_ovf, m_tog, dut_pulses;

  typedef struct {
    bit evt;
    bit clr;
    bit p;
    int pend;
    bit busy;
    bit ovf;
  } vec_t;
  vec_t tbl [20];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    last_l = -1000;
    m_pend = 0;
    m_ovf  = 0;
    m_tog  = 0;
  endtask

  // A launch decided at cycle d drives pulse_out over d+1..d+WIDTH; next launch no earlier than d+GAP.
  task automatic cycle(input bit e, input bit c);
    bit l, a;
    int dt;
    evt = e;
    clr = c;
    l = ((cyc - last_l) >= int'(GAP)) && ((m_pend != 0) || e);
    a = e && ((m_pend < int'(DEPTH)) || l);
    if (e && !a) m_ovf = 1;
    else if (c)  m_ovf = 0;
    m_pend = m_pend + int'(a) - int'(l);
    if (l) begin
      last_l = cyc;
      m_tog  = m_tog ^ 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    dt = cyc - last_l;
    check("pulse_out", int'(pulse), int'(dt >= 1 && dt <= int'(WIDTH)));
    check("pending", int'(pend), m_pend);
    check("busy", int'(busy), int'((dt >= 1 && dt <= int'(GAP)) || m_pend != 0));
    check("overflow", int'(ovf), m_ovf);
`ifdef PULSE_GEN_TOGGLE_EN
    check("toggle_out", int'(tog), m_tog);
`endif
    if (pulse) dut_pulses++;
  endtask

  initial begin
    rst_n = 1'b0;
    evt = 1'b0; clr = 1'b0; evt2 = 1'b0; clr2 = 1'b0;
    dut_pulses = 0;
    model_reset();

    // Burst table: row i drives cycle i, expectations are for cycle i+1
    for (int i = 0; i < 20; i++) begin
      int t;
      t = i + 1;
      tbl[i].evt  = (i <= 2);
      tbl[i].clr  = 1'b0;
      tbl[i].p    = (t == 1) || (t == 9) || (t == 17);
      tbl[i].pend = (t == 2) ? 1 : (t >= 3 && t <= 8) ? 2 : (t >= 9 && t <= 16) ? 1 : 0;
      tbl[i].busy = 1'b1;
      tbl[i].ovf  = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst pulse_out", int'(pulse), 0);
    check("rst pending", int'(pend), 0);
    check("rst busy", int'(busy), 0);
    check("rst overflow", int'(ovf), 0);
`ifdef PULSE_GEN_TOGGLE_EN
    check("rst toggle_out", int'(tog), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].evt, tbl[i].clr);
      check("burst pulse_out", int'(pulse), int'(tbl[i].p));
      check("burst pending", int'(pend), tbl[i].pend);
      check("burst busy", int'(busy), int'(tbl[i].busy));
      check("burst overflow", int'(ovf), int'(tbl[i].ovf));
    end
`ifdef PULSE_GEN_TOGGLE_EN
    check("burst toggle end", int'(tog), 1);
`endif
    repeat (10) cycle(1'b0, 1'b0);

    // Single event at relative cycle 5
    for (int i = 0; i < 16; i++) begin
      cycle(i == 5, 1'b0);
      check("single pulse_out", int'(pulse), int'(i + 1 == 6));
      check("single busy", int'(busy), int'(i + 1 >= 6 && i + 1 <= 13));
      check("single pending", int'(pend), 0);
    end

    // Saturation with clr_ovf coinciding with a drop
    dut_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, i == 19);
      if (i == 17) check("sat pending full", int'(pend), 15);
      if (i == 18) check("sat overflow set", int'(ovf), 1);
      if (i == 19) check("sat overflow kept", int'(ovf), 1);
    end
    check("sat pending held", int'(pend), 15);
    repeat (140) cycle(1'b0, 1'b0);
    check("sat pulse count", dut_pulses, 18);
    check("ovf before clear", int'(ovf), 1);
    cycle(1'b0, 1'b1);
    check("ovf clear", int'(ovf), 0);

    // WIDTH=3, GAP=5 shape on the second instance
    for (int i = 0; i < 12; i++) begin
      evt2 = (i <= 1);
      cycle(1'b0, 1'b0);
      check("shape pulse_out", int'(pulse2),
            int'((i + 1 >= 1 && i + 1 <= 3) || (i + 1 >= 6 && i + 1 <= 8)));
    end
    evt2 = 1'b0;
    check("shape pending", int'(pend2), 0);
    check("shape busy", int'(busy2), 0);
    check("shape overflow", int'(ovf2), 0);

    // Reset during a pulse with two events still queued
    repeat (10) cycle(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(i <= 3, 1'b0);
    check("pre-rst pulse_out", int'(pulse), 1);
    check("pre-rst pending", int'(pend), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst pulse_out", int'(pulse), 0);
    check("async rst pending", int'(pend), 0);
    check("async rst busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dut_pulses = 0;
    repeat (30) cycle(1'b0, 1'b0);
    check("post-rst pulse count", dut_pulses, 0);

    // Random traffic with varying load
    for (int seg = 0; seg < 12; seg++) begin
      int bias;
      bias = (seg % 3 == 0) ? 15 : (seg % 3 == 1) ? 60 : 97;
      for (int i = 0; i < 170; i++)
        cycle($urandom_range(0, 99) < bias, $urandom_range(0, 31) == 0);
    end
    repeat (150) cycle(1'b0, 1'b0);
    check("final idle busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
